// File: rtl/hold_value_serializer_if.sv
// Handshake/bus bundle for hold_value_serializer.
// master: upstream/downstream side (drives load, parallel data, ready).
// slave : the serializer (drives idle, valid, element, index, last, done).
interface hold_value_serializer_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SIZE  = 25
);
   localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic             i_load;
   logic [WIDTH-1:0] i_din [SIZE];
   logic             o_idle;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_dout;
   logic [IW-1:0]    o_index;
   logic             o_last;
   logic             o_done;

   modport master (
      output i_load, i_din, i_ready,
      input  o_idle, o_valid, o_dout, o_index, o_last, o_done
   );

   modport slave (
      input  i_load, i_din, i_ready,
      output o_idle, o_valid, o_dout, o_index, o_last, o_done
   );
endinterface

// File: rtl/hold_value_serializer.sv
// Captures a parallel array of SIZE elements in one cycle, then streams the
// elements out in index order with valid/ready backpressure.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   bus.i_load capture request, honoured only while idle
//   bus.i_din  parallel array to capture
//   bus.i_ready downstream accepts the current element
//   bus.o_idle / o_valid / o_dout / o_index / o_last  stream outputs
//   bus.o_done one-cycle pulse after the final element transfers
module hold_value_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SIZE  = 25
) (
   input logic                   i_clk,
   input logic                   i_rst,
   hold_value_serializer_if.slave bus
);
   localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             load_en;
   logic             is_last;
   logic [WIDTH-1:0] snap_q [SIZE];

   assign is_last = (cnt_q == IW'(SIZE - 1));

   // State, counter and done-pulse registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Snapshot registers; written only on an accepted load
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(SIZE); i++) snap_q[i] <= '0;
      end else if (load_en) begin
         for (int i = 0; i < int'(SIZE); i++) snap_q[i] <= bus.i_din[i];
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      load_en = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_load) begin
               load_en = 1'b1;
               cnt_d   = '0;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // Load requests are ignored here, including on the last transfer
            if (bus.i_ready) begin
               if (is_last) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs, decoded from registered state only
   always_comb begin
      bus.o_idle  = 1'b1;
      bus.o_valid = 1'b0;
      bus.o_last  = 1'b0;
      bus.o_index = cnt_q;
      bus.o_done  = done_q;
      bus.o_dout  = '0;
      // Explicit mux keeps the select in range for any SIZE
      for (int i = 0; i < int'(SIZE); i++) begin
         if (cnt_q == IW'(i)) bus.o_dout = snap_q[i];
      end
      if (state_q == ST_STREAM) begin
         bus.o_idle  = 1'b0;
         bus.o_valid = 1'b1;
         bus.o_last  = is_last;
      end
   end
endmodule

// File: tb/tb_hold_value_serializer.sv
module tb_hold_value_serializer;
   localparam int unsigned N = 25;

   logic clk;
   logic rst;

   hold_value_serializer_if #(.WIDTH(8), .SIZE(N)) bus_a ();
   hold_value_serializer_if #(.WIDTH(8), .SIZE(1)) bus_b ();

   hold_value_serializer #(.WIDTH(8), .SIZE(N)) dut_a (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_a.slave)
   );

   hold_value_serializer #(.WIDTH(8), .SIZE(1)) dut_b (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: the elements still owed downstream, in order
   logic [7:0] exp_q[$];
   int         exp_pos   = 0;
   logic [7:0] exp_snap0 = 8'h00;
   logic       exp_done  = 1'b0;

   int cyc    = 0;
   int xfers  = 0;
   int t_last = -1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_a(input string tag);
      logic busy;
      busy = (exp_q.size() != 0);
      chk({tag, "_valid"}, 32'(bus_a.o_valid), 32'(busy));
      chk({tag, "_idle"},  32'(bus_a.o_idle),  32'(!busy));
      chk({tag, "_index"}, 32'(bus_a.o_index), busy ? 32'(exp_pos) : 32'd0);
      chk({tag, "_last"},  32'(bus_a.o_last),  32'(exp_q.size() == 1));
      chk({tag, "_dout"},  32'(bus_a.o_dout),  busy ? 32'(exp_q[0]) : 32'(exp_snap0));
      chk({tag, "_done"},  32'(bus_a.o_done),  32'(exp_done));
   endtask

   // One clock edge: advance the model with the current inputs, then sample
   task automatic tick(input string tag);
      logic nd;
      nd = 1'b0;
      if (bus_a.o_valid && bus_a.i_ready) begin
         xfers++;
         if (bus_a.o_last) t_last = cyc;
      end
      if (rst) begin
         exp_q.delete();
         exp_pos   = 0;
         exp_snap0 = 8'h00;
      end else if (exp_q.size() != 0) begin
         if (bus_a.i_ready) begin
            void'(exp_q.pop_front());
            exp_pos++;
            if (exp_q.size() == 0) begin
               exp_pos = 0;
               nd      = 1'b1;
            end
         end
      end else if (bus_a.i_load) begin
         for (int i = 0; i < int'(N); i++) exp_q.push_back(bus_a.i_din[i]);
         exp_pos   = 0;
         exp_snap0 = bus_a.i_din[0];
      end
      exp_done = nd;
      @(posedge clk);
      #1;
      cyc++;
      check_a(tag);
   endtask

   task automatic set_ramp();
      for (int i = 0; i < int'(N); i++) bus_a.i_din[i] = 8'(3 * i + 1);
   endtask

   initial begin
      int k;
      int t_first;
      rst = 1'b1;
      bus_a.i_load = 1'b0;
      bus_a.i_ready = 1'b0;
      for (int i = 0; i < int'(N); i++) bus_a.i_din[i] = 8'h00;
      bus_b.i_load = 1'b0;
      bus_b.i_ready = 1'b0;
      bus_b.i_din[0] = 8'h00;

      tick("rst");
      tick("rst");
      chk("rst_b_idle",  32'(bus_b.o_idle),  32'd1);
      chk("rst_b_valid", 32'(bus_b.o_valid), 32'd0);
      rst = 1'b0;

      // Basic stream
      set_ramp();
      bus_a.i_ready = 1'b1;
      bus_a.i_load  = 1'b1;
      xfers = 0;
      tick("basic_load");
      bus_a.i_load = 1'b0;
      chk("basic_first_dout", 32'(bus_a.o_dout), 32'd1);
      for (k = 0; k < 40 && !bus_a.o_done; k++) tick("basic");
      chk("basic_done_seen", 32'(bus_a.o_done), 32'd1);
      chk("basic_len", 32'(xfers), 32'(N));
      tick("basic_after");

      // Backpressure at index 7
      xfers = 0;
      bus_a.i_load = 1'b1;
      tick("bp_load");
      bus_a.i_load = 1'b0;
      for (k = 0; k < 40 && bus_a.o_index != 5'd7; k++) tick("bp_run");
      chk("bp_reach7", 32'(bus_a.o_index), 32'd7);
      bus_a.i_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         tick("bp_hold");
         chk("bp_hold_dout",  32'(bus_a.o_dout),  32'd22);
         chk("bp_hold_index", 32'(bus_a.o_index), 32'd7);
      end
      bus_a.i_ready = 1'b1;
      tick("bp_resume");
      chk("bp_resume_dout",  32'(bus_a.o_dout),  32'd25);
      chk("bp_resume_index", 32'(bus_a.o_index), 32'd8);
      for (k = 0; k < 40 && !bus_a.o_done; k++) tick("bp_tail");
      chk("bp_len", 32'(xfers), 32'(N));
      tick("bp_after");

      // Snapshot isolation and ignored mid-stream load
      bus_a.i_load = 1'b1;
      tick("iso_load");
      bus_a.i_load = 1'b0;
      for (int i = 0; i < int'(N); i++) bus_a.i_din[i] = 8'hFF;
      tick("iso_a");
      tick("iso_b");
      bus_a.i_load = 1'b1;
      tick("iso_pulse");
      bus_a.i_load = 1'b0;
      for (k = 0; k < 80 && !bus_a.o_done; k++) begin
         if (bus_a.o_valid)
            chk("iso_ramp", 32'(bus_a.o_dout), 32'(8'(3 * int'(bus_a.o_index) + 1)));
         bus_a.i_ready = ($urandom_range(0, 2) != 0);
         tick("iso");
      end
      chk("iso_done_seen", 32'(bus_a.o_done), 32'd1);
      bus_a.i_ready = 1'b1;
      tick("iso_after");

      // Back-to-back arrays with i_load held high
      set_ramp();
      bus_a.i_load = 1'b1;
      t_last = -1;
      tick("b2b_load");
      for (k = 0; k < 40 && t_last < 0; k++) tick("b2b_first");
      chk("b2b_done", 32'(bus_a.o_done), 32'd1);
      t_first = -1;
      for (k = 0; k < 5 && t_first < 0; k++) begin
         tick("b2b_gap");
         if (bus_a.o_valid && bus_a.o_index == 5'd0) t_first = cyc;
      end
      chk("b2b_gap_cycles", 32'(t_first - t_last), 32'd2);
      bus_a.i_load = 1'b0;
      for (k = 0; k < 40 && !bus_a.o_done; k++) tick("b2b_second");
      tick("b2b_after");

      // Reset mid-stream at index 12
      bus_a.i_load = 1'b1;
      tick("rm_load");
      bus_a.i_load = 1'b0;
      for (k = 0; k < 40 && bus_a.o_index != 5'd12; k++) tick("rm_run");
      chk("rm_reach12", 32'(bus_a.o_index), 32'd12);
      rst = 1'b1;
      tick("rm_rst");
      rst = 1'b0;
      chk("rm_valid", 32'(bus_a.o_valid), 32'd0);
      chk("rm_index", 32'(bus_a.o_index), 32'd0);
      chk("rm_dout",  32'(bus_a.o_dout),  32'd0);
      chk("rm_idle",  32'(bus_a.o_idle),  32'd1);
      tick("rm_nodone");
      tick("rm_nodone");
      bus_a.i_load = 1'b1;
      tick("rm_reload");
      bus_a.i_load = 1'b0;
      for (k = 0; k < 40 && !bus_a.o_done; k++) tick("rm_stream");

      // Random loads, data and backpressure
      for (int n = 0; n < 600; n++) begin
         bus_a.i_ready = ($urandom_range(0, 3) != 0);
         bus_a.i_load  = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < int'(N); i++) bus_a.i_din[i] = 8'($urandom);
         tick("rand");
      end
      bus_a.i_load  = 1'b0;
      bus_a.i_ready = 1'b1;
      for (k = 0; k < 40 && bus_a.o_valid; k++) tick("rand_drain");
      tick("rand_idle");

      // SIZE=1 instance
      bus_b.i_din[0] = 8'hA5;
      bus_b.i_load   = 1'b1;
      tick("s1_load");
      bus_b.i_load = 1'b0;
      chk("s1_valid", 32'(bus_b.o_valid), 32'd1);
      chk("s1_index", 32'(bus_b.o_index), 32'd0);
      chk("s1_last",  32'(bus_b.o_last),  32'd1);
      chk("s1_dout",  32'(bus_b.o_dout),  32'hA5);
      bus_b.i_din[0] = 8'h3C;
      bus_b.i_ready  = 1'b1;
      tick("s1_xfer");
      chk("s1_done",       32'(bus_b.o_done),  32'd1);
      chk("s1_idle",       32'(bus_b.o_idle),  32'd1);
      chk("s1_valid_low",  32'(bus_b.o_valid), 32'd0);
      tick("s1_after");
      chk("s1_done_pulse", 32'(bus_b.o_done),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
